// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   NDIG / SEG_W   display geometry (4 digits, 7 segments each)
//   SEG_OFF/AN_OFF all-dark values for the active-low segment and anode buses
//   scan_state_e   IDLE / RUN state of the slot timer
//   digit_word     pick digit i's segment word out of the packed 28-bit bus
//   anode_drive    one-cold anode pattern for a digit (or all off)
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int NDIG  = 4;
  localparam int SEG_W = 7;
  localparam int IDX_W = 2;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [NDIG-1:0]  AN_OFF  = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

  // Digit i lives on word[7i+6:7i].
  function automatic logic [SEG_W-1:0] digit_word(
    input logic [NDIG*SEG_W-1:0] word,
    input logic [IDX_W-1:0]      idx
  );
    return word[int'(idx)*SEG_W +: SEG_W];
  endfunction

  // Active-low anodes: at most one bit low, and only when the digit is on.
  function automatic logic [NDIG-1:0] anode_drive(
    input logic             on,
    input logic [IDX_W-1:0] idx
  );
    logic [NDIG-1:0] a;
    a = AN_OFF;
    if (on) a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// -----------------------------------------------------------------------------
// seg7_slot_timer
// IDLE/RUN state plus the slot counter (cnt, 0..TICK_DIV-1) and digit index
// (idx, 0..3). Each slot opens with GAP_CYC dead cycles before the digit may
// light, so the anode of the previous digit is never on alongside the next.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en_i         1 = scan, 0 = return to IDLE on the next edge
//   idx_o        registered digit index
//   lit_o        registered "slot past its dead time" (RUN && cnt >= GAP_CYC)
//   snap_o       next edge starts a frame: capture inputs, pulse frame
//   idx_d_o      next-state digit index
//   lit_d_o      next-state lit flag
// -----------------------------------------------------------------------------
module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int GAP_CYC  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             lit_o,
  output logic             snap_o,
  output logic [IDX_W-1:0] idx_d_o,
  output logic             lit_d_o
);

  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_START = CNT_W'(GAP_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would make the result
  // depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. Counters default to 0, which is also their IDLE value
  // and their value at every frame start.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = '0;
    snap_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_RUN;
          snap_o  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // idx wraps 3 -> 0 by width; that wrap is the frame boundary.
          idx_d  = idx_q + IDX_W'(1);
          snap_o = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          idx_d = idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs, in both registered and next-state form. The scanner registers
  // its pins from the next-state versions so they line up with cnt/idx.
  always_comb begin
    idx_o   = idx_q;
    idx_d_o = idx_d;
    lit_o   = (state_q == ST_RUN) && (cnt_q >= GAP_START);
    lit_d_o = (state_d == ST_RUN) && (cnt_d >= GAP_START);
  end

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed driver for a 4-digit common-anode display. Snapshots the
// decoder's segment words and blank mask once per frame and scans digits
// 0..3, each slot starting with a dead time with all anodes off.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          1 = scan, 0 = display off and idle
//   seg_in      28-bit active-low segment words, digit i on [7i+6:7i]
//   blank_in    1 = keep digit i dark
//   an          active-low anodes, at most one low
//   seg         shared active-low segment bus
//   frame       one-cycle pulse on the cycle a new snapshot is shown
// -----------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int GAP_CYC  = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NDIG*SEG_W-1:0] seg_in,
  input  logic [NDIG-1:0]       blank_in,
  output logic [NDIG-1:0]       an,
  output logic [SEG_W-1:0]      seg,
  output logic                  frame
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lit_q, lit_d;
  logic             snap;

  seg7_slot_timer #(
    .TICK_DIV (TICK_DIV),
    .GAP_CYC  (GAP_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .idx_o   (idx_q),
    .lit_o   (lit_q),
    .snap_o  (snap),
    .idx_d_o (idx_d),
    .lit_d_o (lit_d)
  );

  logic [NDIG*SEG_W-1:0] snap_seg_q, snap_seg_d;
  logic [NDIG-1:0]       snap_blank_q, snap_blank_d;
  logic [NDIG-1:0]       an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  frame_q, frame_d;
  logic                  digit_on_d;

  // Decode from the next-state snapshot, so the first slot of a frame already
  // shows the freshly captured word (matters when GAP_CYC is 0).
  always_comb begin
    snap_seg_d   = snap ? seg_in   : snap_seg_q;
    snap_blank_d = snap ? blank_in : snap_blank_q;
    digit_on_d   = lit_d && !snap_blank_d[idx_d];
    an_d         = anode_drive(digit_on_d, idx_d);
    seg_d        = digit_on_d ? digit_word(snap_seg_d, idx_d) : SEG_OFF;
    frame_d      = snap;
  end

  // NOTE: the snapshot is a plain register bank, not a RAM, so it is reset to
  // all-dark; that keeps it defined even though it is only shown once a frame
  // has captured real data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_seg_q   <= '1;
      snap_blank_q <= AN_OFF;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_q      <= 1'b0;
    end else begin
      snap_seg_q   <= snap_seg_d;
      snap_blank_q <= snap_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_q      <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

  // The output flops must always equal a decode of the registered state.
  logic             digit_on_q;
  logic [NDIG-1:0]  chk_an;
  logic [SEG_W-1:0] chk_seg;

  always_comb begin
    digit_on_q = lit_q && !snap_blank_q[idx_q];
    chk_an     = anode_drive(digit_on_q, idx_q);
    chk_seg    = digit_on_q ? digit_word(snap_seg_q, idx_q) : SEG_OFF;
  end

  out_matches_state: assert property (
    @(posedge clk) disable iff (!rst_n) (an_q == chk_an) && (seg_q == chk_seg)
  );

endmodule
